// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared CPU types for the fetch unit: FSM states, reset PC, control bundle
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_EXEC      = 2'd1,
    S_WAIT_DMEM = 2'd2,
    S_UPDATE    = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic branch;
    logic jz;
    logic js;
    logic jmem;
    logic bmem;
    logic alu_zero;
  } ctl_t;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational branch/jump target computation and next-PC priority select
module next_pc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_instr,
  input  ctl_t        i_ctl,
  input  logic        i_z,
  input  logic        i_mem_eq,
  input  logic [31:0] i_dmem_data,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_jmem_target;

  assign w_pc_plus4    = i_pc + 32'd4;
  assign w_br_off      = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
  assign w_br_target   = w_pc_plus4 + w_br_off;
  assign w_jmp_target  = {w_pc_plus4[31:28], i_instr, 2'b00};
  // Misaligned memory-indirect targets are word-aligned rather than trapped.
  assign w_jmem_target = i_dmem_data & 32'hFFFF_FFFC;

  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_ctl.jmem)                        o_next_pc = w_jmem_target;
    else if (i_ctl.bmem && i_mem_eq)       o_next_pc = w_br_target;
    else if (i_ctl.jz && i_z)              o_next_pc = w_jmp_target;
    else if (i_ctl.js)                     o_next_pc = w_jmp_target;
    else if (i_ctl.branch && i_ctl.alu_zero) o_next_pc = w_br_target;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - multi-cycle fetch FSM holding PC, instruction, Z flag and latched controls
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        branch,
  input  logic        jz,
  input  logic        js,
  input  logic        jmem,
  input  logic        bmem,
  input  logic        alu_zero,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  input  logic        mem_eq,
  input  logic        flag_we,
  input  logic        flag_z,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        exc_misalign
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_dmem_data;
  ctl_t         r_ctl;
  logic         r_z;
  logic         r_z_snap;
  logic         r_mem_eq;
  logic         r_exc;
  logic         r_instr_valid;
  logic [31:0]  w_next_pc;

  next_pc_sel u_next_pc_sel (
    .i_pc        (r_pc),
    .i_instr     (r_instr[25:0]),
    .i_ctl       (r_ctl),
    .i_z         (r_z_snap),
    .i_mem_eq    (r_mem_eq),
    .i_dmem_data (r_dmem_data),
    .o_next_pc   (w_next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_dmem_data   <= '0;
      r_ctl         <= '0;
      r_z           <= 1'b0;
      r_z_snap      <= 1'b0;
      r_mem_eq      <= 1'b0;
      r_exc         <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ex_done) begin
            r_ctl    <= {branch, jz, js, jmem, bmem, alu_zero};
            // jz must see the flag as it stood before this instruction's own update.
            r_z_snap <= r_z;
            if (flag_we) r_z <= flag_z;
            if (jmem || bmem) begin
              r_state <= S_WAIT_DMEM;
            end else begin
              r_instr_valid <= 1'b0;
              r_state       <= S_UPDATE;
            end
          end
        end
        S_WAIT_DMEM: begin
          if (dmem_ready) begin
            r_dmem_data   <= dmem_rdata;
            r_mem_eq      <= mem_eq;
            r_exc         <= r_ctl.jmem & (|dmem_rdata[1:0]);
            r_instr_valid <= 1'b0;
            r_state       <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_pc    <= w_next_pc;
          r_exc   <= 1'b0;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem_req     = (r_state == S_FETCH);
  assign imem_addr    = r_pc;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign pc           = r_pc;
  assign pc_plus4     = r_pc + 32'd4;
  assign exc_misalign = r_exc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized bench for pc_fetch_unit against an instruction-level PC model
module tb_pc_fetch_unit;

  localparam logic [5:0] C_BR = 6'b100000;
  localparam logic [5:0] C_JZ = 6'b010000;
  localparam logic [5:0] C_JS = 6'b001000;
  localparam logic [5:0] C_JM = 6'b000100;
  localparam logic [5:0] C_BM = 6'b000010;
  localparam logic [5:0] C_AZ = 6'b000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done;
  logic        branch, jz, js, jmem, bmem, alu_zero;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_eq;
  logic        flag_we;
  logic        flag_z;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exc_misalign;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .ex_done      (ex_done),
    .branch       (branch),
    .jz           (jz),
    .js           (js),
    .jmem         (jmem),
    .bmem         (bmem),
    .alu_zero     (alu_zero),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .mem_eq       (mem_eq),
    .flag_we      (flag_we),
    .flag_z       (flag_z),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .exc_misalign (exc_misalign)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          exc_seen = 0;
  bit          chk_en = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic        m_z = 1'b0;
  logic        e_req, e_valid, e_exc;
  logic [31:0] e_pc, e_instr;
  logic [31:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Next PC from the architectural rules, one instruction at a time.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic [5:0] c, input logic z,
                                             input logic [31:0] d, input logic eq);
    logic [31:0] seq, br, jt;
    int off;
    seq = p + 32'd4;
    off = int'($signed(w[15:0]));
    br  = seq + 32'(off * 4);
    jt  = (seq & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
    if (c[2])               return d - (d % 32'd4);
    if (c[1] && eq)         return br;
    if (c[4] && z)          return jt;
    if (c[3])               return jt;
    if (c[5] && c[0])       return br;
    return seq;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, e_pc);
      chk("pc_plus4", pc_plus4, e_pc + 32'd4);
      chk1("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, e_pc);
      chk1("instr_valid", instr_valid, e_valid);
      chk("instr", instr, e_instr);
      chk1("exc_misalign", exc_misalign, e_exc);
      if (exc_misalign) exc_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    ex_done    = 1'($urandom);
    dmem_ready = 1'($urandom);
    {branch, jz, js, jmem, bmem, alu_zero} = 6'($urandom);
    flag_we    = 1'($urandom);
    flag_z     = 1'($urandom);
    mem_eq     = 1'($urandom);
    dmem_rdata = $urandom;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_instr(input logic [31:0] word, input int fwait, input int edly,
                          input logic [5:0] ctl, input logic fwe, input logic fz,
                          input int ddly, input logic [31:0] ddata, input logic meq,
                          input int abort_at);
    logic zb;
    e_req = 1'b1; e_valid = 1'b0; e_pc = m_pc; e_instr = m_instr; e_exc = 1'b0;
    for (int k = 0; k <= fwait; k++) begin
      noise();
      imem_ready = (k == fwait);
      if (k == fwait) imem_rdata = word;
      if (k == 0) last_addr = imem_addr;
      step();
    end
    m_instr = word;
    e_req = 1'b0; e_valid = 1'b1; e_instr = word;
    for (int k = 0; k <= edly; k++) begin
      noise();
      ex_done = (k == edly);
      if (k == edly) begin
        {branch, jz, js, jmem, bmem, alu_zero} = ctl;
        flag_we = fwe;
        flag_z  = fz;
      end
      step();
    end
    zb = m_z;
    if (fwe) m_z = fz;
    if (ctl[2] || ctl[1]) begin
      for (int k = 0; k <= ddly; k++) begin
        noise();
        dmem_ready = (k == ddly);
        if (k == ddly) begin
          dmem_rdata = ddata;
          mem_eq     = meq;
        end
        if (k == abort_at) begin
          chk_en = 1'b0;
          rst_n  = 1'b0;
          #1;
          chk("abort pc", pc, 32'h0);
          chk1("abort instr_valid", instr_valid, 1'b0);
          chk("abort instr", instr, 32'h0);
          chk1("abort exc", exc_misalign, 1'b0);
          step();
          rst_n   = 1'b1;
          m_pc    = 32'h0;
          m_z     = 1'b0;
          m_instr = 32'h0;
          noise();
          chk_en  = 1'b1;
          return;
        end
        step();
      end
    end
    noise();
    e_valid = 1'b0;
    e_exc   = ctl[2] && ((ddata % 32'd4) != 32'd0);
    step();
    m_pc = model_next(m_pc, word, ctl, zb, ddata, meq);
  endtask

  initial begin
    rst_n = 1'b0;
    noise();
    #2;
    chk("reset pc async", pc, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pc", pc, 32'h0);
    chk("reset pc_plus4", pc_plus4, 32'h4);
    chk("reset instr", instr, 32'h0);
    chk1("reset instr_valid", instr_valid, 1'b0);
    chk1("reset exc", exc_misalign, 1'b0);
    step();
    rst_n = 1'b1;
    chk1("imem_req after release", imem_req, 1'b1);
    chk_en = 1'b1;

    for (int i = 0; i < 3; i++) begin
      do_instr(32'h0, 0, 0, 6'd0, 1'b0, 1'b0, 0, 32'h0, 1'b0, -1);
      chk("seq fetch addr", last_addr, 32'(4 * i));
    end
    do_instr(32'h0000_0040, 0, 0, C_JS, 1'b0, 1'b0, 0, 32'h0, 1'b0, -1);
    chk("js to 0x100", pc, 32'h0000_0100);
    do_instr(32'h0000_FFFE, 0, 1, C_BR | C_AZ, 1'b0, 1'b0, 0, 32'h0, 1'b0, -1);
    chk("branch taken back", pc, 32'h0000_00FC);
    do_instr(32'h0000_0000, 1, 0, C_BR | C_AZ, 1'b0, 1'b0, 0, 32'h0, 1'b0, -1);
    chk("branch zero offset", pc, 32'h0000_0100);
    do_instr(32'h0000_FFFE, 0, 0, C_BR, 1'b0, 1'b0, 0, 32'h0, 1'b0, -1);
    chk("branch not taken", pc, 32'h0000_0104);

    do_instr(32'h0, 1, 0, C_JM, 1'b1, 1'b0, 2, 32'h0FFF_FFFC, 1'b0, -1);
    chk("jmem to 0x0ffffffc", pc, 32'h0FFF_FFFC);
    do_instr(32'h0, 0, 0, 6'd0, 1'b1, 1'b1, 0, 32'h0, 1'b0, -1);
    chk("flag set instr", pc, 32'h1000_0000);
    do_instr(32'h0000_0040, 0, 0, C_JZ, 1'b0, 1'b0, 0, 32'h0, 1'b0, -1);
    chk("jz taken", pc, 32'h1000_0100);
    do_instr(32'h0, 0, 0, C_JM, 1'b1, 1'b0, 0, 32'h1000_0000, 1'b0, -1);
    do_instr(32'h0000_0040, 0, 0, C_JZ, 1'b1, 1'b1, 0, 32'h0, 1'b0, -1);
    chk("jz same-edge flag", pc, 32'h1000_0004);

    exc_seen = 0;
    do_instr(32'h0, 0, 0, C_JM, 1'b0, 1'b0, 5, 32'h0000_2006, 1'b0, -1);
    chk("jmem misaligned pc", pc, 32'h0000_2004);
    chk("exc pulse count", 32'(exc_seen), 32'd1);
    do_instr(32'h0, 0, 0, C_JM | C_BR | C_AZ, 1'b0, 1'b0, 1, 32'h0000_3000, 1'b1, -1);
    chk("jmem beats branch", pc, 32'h0000_3000);
    do_instr(32'h0, 0, 0, C_BM, 1'b0, 1'b0, 1, 32'h0, 1'b1, -1);
    chk("bmem taken", pc, 32'h0000_3004);
    do_instr(32'h0, 0, 0, C_JM, 1'b0, 1'b0, 4, 32'h0000_5000, 1'b0, 2);
    do_instr(32'h0, 0, 0, 6'd0, 1'b0, 1'b0, 0, 32'h0, 1'b0, -1);
    chk("after abort", pc, 32'h0000_0004);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] c;
      c = 6'($urandom & $urandom);
      c[0] = 1'($urandom);
      do_instr($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), c,
               1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), $urandom,
               1'($urandom), -1);
    end
    chk_en = 1'b0;
    chk("final model pc", pc, m_pc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
